// File: rtl/decode_pipe.sv
// MIPS decode stage: regfile with optional write-back bypass, main control decode, load-use stall, ID/EX register.
// Latency 1 cycle to ID/EX; stall is combinational to fetch; flush or stall injects a bubble (valid_ex=0).
module decode_pipe #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int WB_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] PCnext,
  input  logic              flush,
  input  logic              RegWrite,
  input  logic [4:0]        wb_reg,
  input  logic [DATA_W-1:0] writeData,
  output logic              stall,
  output logic              valid_ex,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2,
  output logic [DATA_W-1:0] imm,
  output logic [8:0]        control,
  output logic [4:0]        rs_ex,
  output logic [4:0]        rt_ex,
  output logic [4:0]        wreg_ex,
  output logic [DATA_W-1:0] PCnextID,
  output logic              illegal
);

  localparam int AW = $clog2(NUM_REGS);

  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic [AW-1:0]     rs_a, rt_a, wb_a;
  logic [8:0]        ctl_dec;
  logic              ill_dec;
  logic              uses_rt;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] rd1, rd2;
  logic              bubble;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign rs_a   = rs[AW-1:0];
  assign rt_a   = rt[AW-1:0];
  assign wb_a   = wb_reg[AW-1:0];

  always_comb begin
    ctl_dec = 9'b0;
    ill_dec = 1'b0;
    uses_rt = 1'b0;
    case (opcode)
      6'b000000: begin ctl_dec = 9'b110000010; uses_rt = 1'b1; end
      6'b100011: ctl_dec = 9'b000101011;
      6'b101011: begin ctl_dec = 9'b000100100; uses_rt = 1'b1; end
      6'b000100: begin ctl_dec = 9'b001010000; uses_rt = 1'b1; end
      6'b001000: ctl_dec = 9'b000100010;
      default:   ill_dec = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (RegWrite && wb_a != '0) begin
      regs[wb_a] <= writeData;
    end
  end

  // Register 0 is hardwired; bypass only applies to a real (nonzero) destination.
  always_comb begin
    rd1 = (rs_a == '0) ? '0 : regs[rs_a];
    rd2 = (rt_a == '0) ? '0 : regs[rt_a];
    if (WB_BYPASS != 0 && RegWrite && wb_a != '0) begin
      if (wb_a == rs_a) rd1 = writeData;
      if (wb_a == rt_a) rd2 = writeData;
    end
  end

  assign stall = if_valid & valid_ex & control[3] & (wreg_ex != 5'd0) &
                 ((wreg_ex == rs) | (uses_rt & (wreg_ex == rt))) & ~flush;

  assign bubble = flush | stall | ~if_valid;

  // Bubbles clear only the qualifying fields; data fields keep their last values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_ex <= 1'b0;
      rdData1  <= '0;
      rdData2  <= '0;
      imm      <= '0;
      control  <= 9'b0;
      rs_ex    <= 5'd0;
      rt_ex    <= 5'd0;
      wreg_ex  <= 5'd0;
      PCnextID <= '0;
      illegal  <= 1'b0;
    end else if (bubble) begin
      valid_ex <= 1'b0;
      control  <= 9'b0;
      illegal  <= 1'b0;
    end else begin
      valid_ex <= 1'b1;
      rdData1  <= rd1;
      rdData2  <= rd2;
      imm      <= DATA_W'($signed(instruction[15:0]));
      control  <= ctl_dec;
      rs_ex    <= rs;
      rt_ex    <= rt;
      wreg_ex  <= ctl_dec[8] ? rd : rt;
      PCnextID <= PCnext;
      illegal  <= ill_dec;
    end
  end

endmodule

// File: tb/tb_decode_pipe.sv
// Bench for decode_pipe: one bypass and one non-bypass instance driven in lockstep, checked against a behavioural model.
module tb_decode_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, if_valid, flush, RegWrite;
  logic [31:0] instruction, PCnext, writeData;
  logic [4:0]  wb_reg;

  logic        stall_b, valid_b, ill_b, stall_n, valid_n, ill_n;
  logic [31:0] rd1_b, rd2_b, imm_b, pc_b, rd1_n, rd2_n, imm_n, pc_n;
  logic [8:0]  ctl_b, ctl_n;
  logic [4:0]  rs_b, rt_b, wr_b, rs_n, rt_n, wr_n;

  decode_pipe #(.DATA_W(32), .NUM_REGS(32), .WB_BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .instruction(instruction), .if_valid(if_valid), .PCnext(PCnext),
    .flush(flush), .RegWrite(RegWrite), .wb_reg(wb_reg), .writeData(writeData),
    .stall(stall_b), .valid_ex(valid_b), .rdData1(rd1_b), .rdData2(rd2_b), .imm(imm_b),
    .control(ctl_b), .rs_ex(rs_b), .rt_ex(rt_b), .wreg_ex(wr_b), .PCnextID(pc_b), .illegal(ill_b));

  decode_pipe #(.DATA_W(32), .NUM_REGS(32), .WB_BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .instruction(instruction), .if_valid(if_valid), .PCnext(PCnext),
    .flush(flush), .RegWrite(RegWrite), .wb_reg(wb_reg), .writeData(writeData),
    .stall(stall_n), .valid_ex(valid_n), .rdData1(rd1_n), .rdData2(rd2_n), .imm(imm_n),
    .control(ctl_n), .rs_ex(rs_n), .rt_ex(rt_n), .wreg_ex(wr_n), .PCnextID(pc_n), .illegal(ill_n));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Opcode table -> {illegal, control}
  function automatic logic [9:0] ref_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return {1'b0, 9'b110000010};
      6'h23:   return {1'b0, 9'b000101011};
      6'h2b:   return {1'b0, 9'b000100100};
      6'h04:   return {1'b0, 9'b001010000};
      6'h08:   return {1'b0, 9'b000100010};
      default: return {1'b1, 9'b0};
    endcase
  endfunction

  // Model state: expected ID/EX contents and architectural register file.
  logic        e_valid, e_ill;
  logic [8:0]  e_ctl;
  logic [4:0]  e_rs, e_rt, e_wr;
  logic [31:0] e_rd1b, e_rd2b, e_rd1n, e_rd2n, e_imm, e_pc;
  logic [31:0] mregs [32];

  initial begin
    logic [9:0]  dec;
    logic [4:0]  m_rs, m_rt, m_rd;
    logic        urt, hz, armed;
    armed = 1'b0;
    e_valid = 0; e_ill = 0; e_ctl = 0; e_rs = 0; e_rt = 0; e_wr = 0;
    e_rd1b = 0; e_rd2b = 0; e_rd1n = 0; e_rd2n = 0; e_imm = 0; e_pc = 0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    forever begin
      @(negedge clk); #1;
      dec  = ref_ctl(instruction[31:26]);
      m_rs = instruction[25:21];
      m_rt = instruction[20:16];
      m_rd = instruction[15:11];
      urt  = (instruction[31:26] == 6'h00) || (instruction[31:26] == 6'h2b) || (instruction[31:26] == 6'h04);
      hz   = if_valid && e_valid && e_ctl[3] && e_wr != 0 &&
             (e_wr == m_rs || (urt && e_wr == m_rt)) && !flush;
      if (armed) begin
        chk("stall_byp", {31'b0, stall_b}, {31'b0, hz});
        chk("stall_nob", {31'b0, stall_n}, {31'b0, hz});
      end
      if (rst) begin
        e_valid = 0; e_ill = 0; e_ctl = 0; e_rs = 0; e_rt = 0; e_wr = 0;
        e_rd1b = 0; e_rd2b = 0; e_rd1n = 0; e_rd2n = 0; e_imm = 0; e_pc = 0;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
      end else begin
        if (if_valid && !flush && !hz) begin
          e_valid = 1;
          e_ctl   = dec[8:0];
          e_ill   = dec[9];
          e_rs    = m_rs;
          e_rt    = m_rt;
          e_wr    = dec[8] ? m_rd : m_rt;
          e_imm   = {{16{instruction[15]}}, instruction[15:0]};
          e_pc    = PCnext;
          e_rd1n  = mregs[m_rs];
          e_rd2n  = mregs[m_rt];
          e_rd1b  = (RegWrite && wb_reg != 0 && wb_reg == m_rs) ? writeData : mregs[m_rs];
          e_rd2b  = (RegWrite && wb_reg != 0 && wb_reg == m_rt) ? writeData : mregs[m_rt];
        end else begin
          e_valid = 0; e_ctl = 0; e_ill = 0;
        end
        if (RegWrite && wb_reg != 0) mregs[wb_reg] = writeData;
      end
      @(posedge clk); #1;
      chk("valid_byp", {31'b0, valid_b}, {31'b0, e_valid});
      chk("valid_nob", {31'b0, valid_n}, {31'b0, e_valid});
      chk("ctl_byp", {23'b0, ctl_b}, {23'b0, e_ctl});
      chk("ctl_nob", {23'b0, ctl_n}, {23'b0, e_ctl});
      chk("ill_byp", {31'b0, ill_b}, {31'b0, e_ill});
      chk("ill_nob", {31'b0, ill_n}, {31'b0, e_ill});
      chk("rd1_byp", rd1_b, e_rd1b);
      chk("rd2_byp", rd2_b, e_rd2b);
      chk("rd1_nob", rd1_n, e_rd1n);
      chk("rd2_nob", rd2_n, e_rd2n);
      chk("imm", imm_b, e_imm);
      chk("pc", pc_b, e_pc);
      chk("rs_ex", {27'b0, rs_b}, {27'b0, e_rs});
      chk("rt_ex", {27'b0, rt_b}, {27'b0, e_rt});
      chk("wreg_ex", {27'b0, wr_b}, {27'b0, e_wr});
      chk("fields_nob", {imm_n ^ pc_n, 12'b0, rs_n, rt_n, wr_n}, {e_imm ^ e_pc, 12'b0, e_rs, e_rt, e_wr});
      armed = 1'b1;
    end
  end

  logic [31:0] pc_ctr = 32'h100;

  task automatic drive(input logic r, input logic [31:0] ins, input logic v, input logic fl,
                       input logic rw, input logic [4:0] wr, input logic [31:0] wd);
    @(negedge clk);
    rst = r; instruction = ins; if_valid = v; flush = fl;
    RegWrite = rw; wb_reg = wr; writeData = wd;
    pc_ctr = pc_ctr + 32'd4;
    PCnext = pc_ctr;
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  localparam logic [31:0] ADD7  = 32'h00A63820;  // add  r7,r5,r6
  localparam logic [31:0] LW8   = 32'h8C080004;  // lw   r8,4(r0)
  localparam logic [31:0] ADD9  = 32'h01084820;  // add  r9,r8,r8
  localparam logic [31:0] ADDIA = 32'h200A0001;  // addi r10,r0,1
  localparam logic [31:0] ADDI3 = 32'h20640000;  // addi r4,r3,0
  localparam logic [31:0] ADDI0 = 32'h20040000;  // addi r4,r0,0
  localparam logic [31:0] ADDIN = 32'h20018000;  // addi r1,r0,0x8000
  localparam logic [31:0] BADOP = 32'hFC000000;

  initial begin
    logic [31:0] pcx;
    rst = 1; instruction = 0; if_valid = 0; PCnext = 0; flush = 0;
    RegWrite = 0; wb_reg = 0; writeData = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    chk("lit_rst_valid", {31'b0, valid_b}, 32'd0);
    chk("lit_rst_rd1", rd1_b, 32'd0);

    drive(0, 0, 0, 0, 1, 5'd5, 32'h12345678);
    drive(0, 0, 0, 0, 1, 5'd6, 32'h12345678);
    drive(0, ADD7, 1, 0, 0, 0, 0);
    pcx = pc_ctr;
    tick();
    chk("lit_add_rd1", rd1_b, 32'h12345678);
    chk("lit_add_rd2", rd2_n, 32'h12345678);
    chk("lit_add_ctl", {23'b0, ctl_b}, {23'b0, 9'b110000010});
    chk("lit_add_wreg", {27'b0, wr_b}, 32'd7);
    chk("lit_add_valid", {31'b0, valid_b}, 32'd1);
    chk("lit_add_pc", pc_b, pcx);

    drive(0, LW8, 1, 0, 0, 0, 0);
    tick();
    chk("lit_lw_ctl", {23'b0, ctl_b}, {23'b0, 9'b000101011});
    chk("lit_lw_imm", imm_b, 32'd4);
    drive(0, ADD9, 1, 0, 0, 0, 0);
    #1 chk("lit_hz_stall", {31'b0, stall_b}, 32'd1);
    tick();
    chk("lit_bubble_valid", {31'b0, valid_b}, 32'd0);
    chk("lit_bubble_ctl", {23'b0, ctl_b}, 32'd0);
    drive(0, ADD9, 1, 0, 0, 0, 0);
    #1 chk("lit_hz_once", {31'b0, stall_b}, 32'd0);
    tick();
    chk("lit_add9_rs", {27'b0, rs_b}, 32'd8);
    chk("lit_add9_rt", {27'b0, rt_b}, 32'd8);
    drive(0, LW8, 1, 0, 0, 0, 0);
    drive(0, ADDIA, 1, 0, 0, 0, 0);
    #1 chk("lit_noh_stall", {31'b0, stall_b}, 32'd0);
    tick();
    chk("lit_addi_wreg", {27'b0, wr_b}, 32'd10);

    drive(0, 0, 0, 0, 1, 5'd3, 32'h11111111);
    drive(0, ADDI3, 1, 0, 1, 5'd3, 32'hDEADBEEF);
    tick();
    chk("lit_bypass_on", rd1_b, 32'hDEADBEEF);
    chk("lit_bypass_off", rd1_n, 32'h11111111);
    drive(0, ADDI3, 1, 0, 0, 0, 0);
    tick();
    chk("lit_after_wb", rd1_n, 32'hDEADBEEF);

    drive(0, ADDI0, 1, 0, 1, 5'd0, 32'hFFFFFFFF);
    tick();
    chk("lit_r0_same", rd1_b, 32'd0);
    drive(0, ADDI0, 1, 0, 0, 0, 0);
    tick();
    chk("lit_r0_later", rd1_n, 32'd0);

    drive(0, ADDIN, 1, 0, 0, 0, 0);
    tick();
    chk("lit_imm_sext", imm_b, 32'hFFFF8000);
    drive(0, BADOP, 1, 0, 0, 0, 0);
    tick();
    chk("lit_illegal", {31'b0, ill_b}, 32'd1);
    chk("lit_illegal_ctl", {23'b0, ctl_b}, 32'd0);

    drive(0, LW8, 1, 0, 0, 0, 0);
    tick();
    drive(0, ADD9, 1, 1, 0, 0, 0);
    #1 chk("lit_flush_stall", {31'b0, stall_b}, 32'd0);
    tick();
    chk("lit_flush_valid", {31'b0, valid_b}, 32'd0);

    drive(0, LW8, 1, 0, 0, 0, 0);
    tick();
    drive(1, ADD7, 1, 0, 1, 5'd5, 32'hAAAA5555);
    tick();
    chk("lit_mrst_valid", {31'b0, valid_b}, 32'd0);
    chk("lit_mrst_ctl", {23'b0, ctl_b}, 32'd0);
    chk("lit_mrst_pc", pc_b, 32'd0);
    drive(0, ADD9, 1, 0, 0, 0, 0);
    #1 chk("lit_mrst_stall", {31'b0, stall_b}, 32'd0);
    tick();
    drive(0, ADD7, 1, 0, 0, 0, 0);
    tick();
    chk("lit_mrst_rf1", rd1_b, 32'd0);
    chk("lit_mrst_rf2", rd2_n, 32'd0);

    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
